// File: rtl/w_input_conditioner_if.sv
// rtl/w_input_conditioner_if.sv - w input conditioner signal bundle; glitch_cnt only with W_COND_GLITCH_CNT_EN
interface w_input_conditioner_if;
    logic       raw_in;
    logic       sample_en;
    logic       w;
    logic       w_rise;
    logic       w_fall;
`ifdef W_COND_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    modport master (
        output raw_in, sample_en,
`ifdef W_COND_GLITCH_CNT_EN
        input  glitch_cnt,
`endif
        input  w, w_rise, w_fall
    );

    modport slave (
        input  raw_in, sample_en,
`ifdef W_COND_GLITCH_CNT_EN
        output glitch_cnt,
`endif
        output w, w_rise, w_fall
    );
endinterface

// File: rtl/w_input_conditioner.sv
// rtl/w_input_conditioner.sv - synchronise, debounce and edge-strobe the raw w input
// Optional aborted-transition counter enabled by defining W_COND_GLITCH_CNT_EN.
module w_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input logic                  Clock,
    input logic                  Resetn,
    w_input_conditioner_if.slave cond
);

    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] CHECK_HI  = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b10;
    localparam logic [1:0] CHECK_LO  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   w_q;
    logic                   rise_q;
    logic                   fall_q;

    // raw_in lands directly in the first flop so the chain can resolve metastability
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cond.raw_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            w_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sync) begin
                        state <= CHECK_HI;
                        cnt   <= '0;
                    end
                end
                CHECK_HI: begin
                    // a contrary sample aborts regardless of sample_en and wins over commit
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cond.sample_en) begin
                        if (cnt == CNT_LAST) begin
                            state  <= STABLE_HI;
                            w_q    <= 1'b1;
                            rise_q <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        state <= CHECK_LO;
                        cnt   <= '0;
                    end
                end
                CHECK_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cond.sample_en) begin
                        if (cnt == CNT_LAST) begin
                            state  <= STABLE_LO;
                            w_q    <= 1'b0;
                            fall_q <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign cond.w      = w_q;
    assign cond.w_rise = rise_q;
    assign cond.w_fall = fall_q;

`ifdef W_COND_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    assign abort = ((state == CHECK_HI) && !sync) || ((state == CHECK_LO) && sync);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            glitch_q <= 8'h00;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'h01;
        end
    end

    assign cond.glitch_cnt = glitch_q;
`endif

endmodule
